// File: rtl/qmfir_run_ctrl.sv
// qmfir_run_ctrl
// Run sequencer for the QM FIR datapath. It streams a programmed number of
// input BRAM words into the filter and applies pending frequency changes
// only between runs. Filter outputs go to the output BRAMs through a
// wrapping write pointer. Busy/done/timeout status and live counts are
// reported to the register block.

module qmfir_run_ctrl #(
  parameter int IN_AW     = 12,
  parameter int OUT_AW    = 7,
  parameter int DRAIN_MAX = 64,
  parameter int DEC_SHIFT = 0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              abort,
  input  logic [IN_AW-1:0]  nsamp,
  input  logic              freq_req,
  input  logic [6:0]        freq_in,
  input  logic              fir_data_valid,
  output logic [IN_AW-1:0]  rd_addr,
  output logic              fir_in_valid,
  output logic              fir_new_freq,
  output logic [6:0]        fir_freq,
  output logic [OUT_AW-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [IN_AW-1:0]  in_cnt,
  output logic [IN_AW-1:0]  out_cnt
);

  localparam int DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_PRIME,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic             run_flag;
  logic [IN_AW-1:0] nsamp_lat;
  logic             freq_pend;
  logic [6:0]       freq_code;
  logic [DCW-1:0]   drain_cnt;

  logic [IN_AW-1:0] out_cnt_nxt;
  logic [IN_AW-1:0] target;
  logic [IN_AW-1:0] in_cnt_inc;
  logic             run_complete;
  logic             freq_any;
  logic [6:0]       freq_code_nxt;

  // The write strobe is combinational so that it lines up with DataValid.
  assign wr_en = fir_data_valid && ((state == S_FEED) || (state == S_DRAIN));

  assign target        = nsamp_lat >> DEC_SHIFT;
  assign in_cnt_inc    = in_cnt + 1'b1;
  assign run_complete  = (out_cnt_nxt >= target);
  assign freq_any      = freq_pend | freq_req;
  assign freq_code_nxt = freq_req ? freq_in : freq_code;

  // Output count after any write in this cycle. It saturates at all-ones.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (wr_en && (out_cnt != '1)) begin
      out_cnt_nxt = out_cnt + 1'b1;
    end
  end

  // Sequencer with registered outputs, the frequency latch and the output pointer.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= S_IDLE;
      run_flag     <= 1'b0;
      nsamp_lat    <= '0;
      freq_pend    <= 1'b0;
      freq_code    <= '0;
      drain_cnt    <= '0;
      rd_addr      <= '0;
      fir_in_valid <= 1'b0;
      fir_new_freq <= 1'b0;
      fir_freq     <= '0;
      wr_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
    end else begin
      fir_new_freq <= 1'b0;

      if (freq_req) begin
        freq_code <= freq_in;
        freq_pend <= 1'b1;
      end

      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
        out_cnt <= out_cnt_nxt;
      end

      if (abort) begin
        state        <= S_IDLE;
        fir_in_valid <= 1'b0;
        busy         <= 1'b0;
        run_flag     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              done      <= 1'b0;
              timeout   <= 1'b0;
              in_cnt    <= '0;
              out_cnt   <= '0;
              wr_addr   <= '0;
              rd_addr   <= '0;
              nsamp_lat <= nsamp;
              if (nsamp == '0) begin
                state <= S_DONE;
              end else if (freq_any) begin
                state        <= S_CFG;
                run_flag     <= 1'b1;
                busy         <= 1'b1;
                fir_new_freq <= 1'b1;
                fir_freq     <= freq_code_nxt;
                freq_pend    <= 1'b0;
              end else begin
                state <= S_PRIME;
                busy  <= 1'b1;
              end
            end else if (freq_any) begin
              state        <= S_CFG;
              run_flag     <= 1'b0;
              fir_new_freq <= 1'b1;
              fir_freq     <= freq_code_nxt;
              freq_pend    <= 1'b0;
            end
          end

          S_CFG: begin
            run_flag <= 1'b0;
            if (run_flag) begin
              state   <= S_PRIME;
              rd_addr <= '0;
            end else begin
              state <= S_IDLE;
            end
          end

          S_PRIME: begin
            state        <= S_FEED;
            fir_in_valid <= 1'b1;
            rd_addr      <= IN_AW'(1);
          end

          S_FEED: begin
            in_cnt <= in_cnt_inc;
            if (in_cnt_inc == nsamp_lat) begin
              fir_in_valid <= 1'b0;
              drain_cnt    <= '0;
              if (run_complete) begin
                state <= S_DONE;
                busy  <= 1'b0;
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              rd_addr <= in_cnt + IN_AW'(2);
            end
          end

          S_DRAIN: begin
            if (run_complete) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else if (drain_cnt == DCW'(DRAIN_MAX - 1)) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end

          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qmfir_run_ctrl.sv
// tb_qmfir_run_ctrl
// Table-driven and randomized runs of qmfir_run_ctrl. Each run's expected
// counts, latencies and flags are derived from the run parameters.

module tb_qmfir_run_ctrl;

  localparam int IN_AW  = 12;
  localparam int OUT_AW = 7;
  localparam int DRAIN_MAX = 64;

  logic              clk;
  logic              arst;
  logic              start;
  logic              abort;
  logic [IN_AW-1:0]  nsamp;
  logic              freq_req;
  logic [6:0]        freq_in;
  logic              fir_data_valid;
  logic [IN_AW-1:0]  rd_addr;
  logic              fir_in_valid;
  logic              fir_new_freq;
  logic [6:0]        fir_freq;
  logic [OUT_AW-1:0] wr_addr;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [IN_AW-1:0]  in_cnt;
  logic [IN_AW-1:0]  out_cnt;

  int nCompared;
  int nMismatched;

  typedef struct {
    int n;
    bit df;
    int code;
    int np;
    int lat;
    bit startAgain;
    int midFreq;
    int expFirst;
    int expWrAddr;
    int expOutCnt;
    int expTimeout;
  } vec_t;

  vec_t vecs[7];

  qmfir_run_ctrl dut (
    .clk            (clk),
    .arst           (arst),
    .start          (start),
    .abort          (abort),
    .nsamp          (nsamp),
    .freq_req       (freq_req),
    .freq_in        (freq_in),
    .fir_data_valid (fir_data_valid),
    .rd_addr        (rd_addr),
    .fir_in_valid   (fir_in_valid),
    .fir_new_freq   (fir_new_freq),
    .fir_freq       (fir_freq),
    .wr_addr        (wr_addr),
    .wr_en          (wr_en),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .in_cnt         (in_cnt),
    .out_cnt        (out_cnt)
  );

  // 100 MHz core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison against a bench-computed value
  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the edge; outputs are read 1ns later
  task automatic applyStimulus(input bit s, input int ns, input bit fr, input int fc,
                               input bit dv, input bit ab);
    int nsv;
    int fcv;
    @(posedge clk);
    #1;
    nsv            = ns;
    fcv            = fc;
    start          = s;
    nsamp          = nsv[IN_AW-1:0];
    freq_req       = fr;
    freq_in        = fcv[6:0];
    fir_data_valid = dv;
    abort          = ab;
    #1;
  endtask

  // Issue one run and compare its observed behaviour with the expected record
  task automatic runOne(input vec_t v, input string tag);
    int firstV, lastV, nValid, rdErr, primeRd, prevRd, nf, nfCode;
    int writes, waErr, doneK, lastWrite, sent, budget;
    bit contiguous, dv, sawFreq;
    int vq[$];
    firstV = -1; lastV = -1; nValid = 0; rdErr = 0; primeRd = -1; nf = 0; nfCode = -1;
    writes = 0; waErr = 0; doneK = -1; lastWrite = -1; sent = 0; contiguous = 1;
    applyStimulus(1'b1, v.n, v.df, v.code, 1'b0, 1'b0);
    prevRd = rd_addr;
    budget = v.n + 250;
    for (int k = 1; k < budget && doneK < 0; k++) begin
      dv = 1'b0;
      if (vq.size() > 0 && vq[0] <= k) begin
        void'(vq.pop_front());
        dv = 1'b1;
        sent++;
      end
      applyStimulus((v.startAgain && k == 5), 17, (v.midFreq >= 0 && k == 4),
                    (v.midFreq >= 0) ? v.midFreq : 0, dv, 1'b0);
      if (fir_in_valid) begin
        if (firstV < 0) begin
          firstV  = k;
          primeRd = prevRd;
        end else if (lastV != k - 1) begin
          contiguous = 1'b0;
        end
        if (int'(rd_addr) != nValid + 1) rdErr++;
        nValid++;
        lastV = k;
        if (nValid <= v.np) vq.push_back(k + v.lat);
      end
      if (fir_new_freq) begin
        nf++;
        nfCode = fir_freq;
      end
      if (wr_en) begin
        if (int'(wr_addr) != (writes % 128)) waErr++;
        writes++;
        lastWrite = k;
      end
      if (done) doneK = k;
      prevRd = rd_addr;
    end
    checkOutput({tag, " done_seen"}, (doneK >= 0), 1);
    checkOutput({tag, " first_valid"}, firstV, v.expFirst);
    checkOutput({tag, " valid_count"}, nValid, v.n);
    checkOutput({tag, " valid_contig"}, contiguous, 1);
    checkOutput({tag, " rd_addr_seq_err"}, rdErr, 0);
    if (v.n != 0) checkOutput({tag, " prime_rd_addr"}, primeRd, 0);
    checkOutput({tag, " new_freq_pulses"}, nf, v.df);
    if (v.df) checkOutput({tag, " fir_freq"}, nfCode, v.code);
    checkOutput({tag, " wr_addr_seq_err"}, waErr, 0);
    checkOutput({tag, " writes"}, writes, v.expOutCnt);
    checkOutput({tag, " final_wr_addr"}, wr_addr, v.expWrAddr);
    checkOutput({tag, " out_cnt"}, out_cnt, v.expOutCnt);
    checkOutput({tag, " in_cnt"}, in_cnt, v.n);
    checkOutput({tag, " timeout"}, timeout, v.expTimeout);
    checkOutput({tag, " busy_end"}, busy, 0);
    if (v.n == 0)
      checkOutput({tag, " done_latency"}, doneK, 2);
    else if (v.expTimeout != 0)
      checkOutput({tag, " timeout_latency"}, doneK - lastV, DRAIN_MAX + 2);
    else
      checkOutput({tag, " done_latency"}, doneK - lastWrite, 2);
    if (v.midFreq >= 0) begin
      sawFreq = 1'b0;
      for (int j = 0; j < 6; j++) begin
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        if (fir_new_freq && !sawFreq) begin
          sawFreq = 1'b1;
          checkOutput({tag, " deferred_freq_code"}, fir_freq, v.midFreq);
          checkOutput({tag, " deferred_freq_busy"}, busy, 0);
        end
      end
      checkOutput({tag, " deferred_freq_seen"}, sawFreq, 1);
    end
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t rv;
    int   oc;
    bit   hit;
    nCompared   = 0;
    nMismatched = 0;
    start = 0; abort = 0; nsamp = '0; freq_req = 0; freq_in = '0; fir_data_valid = 0;

    //               n   df code  np lat sa  mf    first wa  oc  to
    vecs[0] = '{     4,  0,  0,    4,  2, 0, -1,    2,    4,  4,  0};
    vecs[1] = '{     2,  1, 42,    2,  3, 0, -1,    3,    2,  2,  0};
    vecs[2] = '{   130,  0,  0,  130,  2, 0, -1,    2,    2, 130, 0};
    vecs[3] = '{     3,  0,  0,    2,  2, 0, -1,    2,    2,  2,  1};
    vecs[4] = '{     0,  0,  0,    0,  1, 0, -1,   -1,    0,  0,  0};
    vecs[5] = '{    10,  0,  0,   10,  1, 1, -1,    2,   10, 10,  0};
    vecs[6] = '{     8,  0,  0,    8,  2, 0, 17,    2,    8,  8,  0};

    arst = 1'b1;
    #3;
    checkOutput("reset rd_addr", rd_addr, 0);
    checkOutput("reset fir_in_valid", fir_in_valid, 0);
    checkOutput("reset fir_new_freq", fir_new_freq, 0);
    checkOutput("reset fir_freq", fir_freq, 0);
    checkOutput("reset wr_addr", wr_addr, 0);
    checkOutput("reset wr_en", wr_en, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset timeout", timeout, 0);
    checkOutput("reset in_cnt", in_cnt, 0);
    checkOutput("reset out_cnt", out_cnt, 0);
    #9;
    arst = 1'b0;
    for (int j = 0; j < 2; j++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // A lone frequency request in IDLE is applied on the very next cycle
    applyStimulus(1'b0, 0, 1'b1, 85, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("idle_freq new_freq", fir_new_freq, 1);
    checkOutput("idle_freq code", fir_freq, 85);
    checkOutput("idle_freq busy", busy, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("idle_freq pulse_len", fir_new_freq, 0);
    for (int j = 0; j < 2; j++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) runOne(vecs[i], $sformatf("vec%0d", i));

    // DataValid outside a run must neither write nor count
    oc = vecs[6].expOutCnt;
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("idle_dv wr_en", wr_en, 0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("idle_dv out_cnt", out_cnt, oc);
    checkOutput("idle_dv wr_addr", wr_addr, vecs[6].expWrAddr);

    // Abort in FEED when in_cnt reaches 5
    applyStimulus(1'b1, 20, 1'b0, 0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int j = 0; j < 30 && !hit; j++) begin
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      if (in_cnt == 4 && fir_in_valid) hit = 1'b1;
    end
    checkOutput("abort reached_cnt4", hit, 1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("abort cycle in_cnt", in_cnt, 5);
    checkOutput("abort cycle valid", fir_in_valid, 1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("abort next valid", fir_in_valid, 0);
    checkOutput("abort next busy", busy, 0);
    checkOutput("abort next done", done, 0);
    checkOutput("abort hold in_cnt", in_cnt, 5);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("abort stays idle valid", fir_in_valid, 0);
    rv = '{3, 0, 0, 3, 2, 0, -1, 2, 3, 3, 0};
    runOne(rv, "post_abort");

    // Randomized runs against the arithmetic run model
    for (int r = 0; r < 8; r++) begin
      rv.n          = $urandom_range(1, 40);
      rv.df         = $urandom_range(0, 1);
      rv.code       = $urandom_range(0, 127);
      rv.np         = rv.n;
      if ($urandom_range(0, 3) == 0) rv.np = rv.n - $urandom_range(1, (rv.n > 1) ? 2 : 1);
      rv.lat        = $urandom_range(1, 4);
      rv.startAgain = 1'b0;
      rv.midFreq    = -1;
      rv.expFirst   = rv.df ? 3 : 2;
      rv.expWrAddr  = rv.np % 128;
      rv.expOutCnt  = rv.np;
      rv.expTimeout = (rv.np < rv.n) ? 1 : 0;
      runOne(rv, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a run
    applyStimulus(1'b1, 20, 1'b0, 0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    #1;
    arst = 1'b1;
    #1;
    checkOutput("arst valid", fir_in_valid, 0);
    checkOutput("arst busy", busy, 0);
    checkOutput("arst rd_addr", rd_addr, 0);
    checkOutput("arst in_cnt", in_cnt, 0);
    checkOutput("arst done", done, 0);
    #2;
    arst = 1'b0;
    for (int j = 0; j < 2; j++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
